// File: rtl/ctrl_50mhz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Definitions shared by the 50 MHz packet producer and the 2 MHz
//            group reader: FSM state encoding, header byte values and the
//            packet/group size. The group size is defined only here.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Accepted packet header bytes.
    localparam logic [7:0] c_hdr_a = 8'hA5;
    localparam logic [7:0] c_hdr_b = 8'hC3;

    // Payload bytes per packet. This must equal the reader's group size.
    // The legal range is 2..16.
    localparam int c_pkt_bytes = 4;

    // Producer FSM states, with an explicit 2-bit encoding.
    typedef enum logic [1:0] {
        HDR_WAIT = 2'b00,
        CAPTURE  = 2'b01,
        BURST    = 2'b10
    } ctrl_state_t;

    // True when a byte matches either accepted header value.
    function automatic logic is_header(input logic [7:0] b,
                                       input logic [7:0] hdr_a,
                                       input logic [7:0] hdr_b);
        return (b == hdr_a) || (b == hdr_b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_50mhz_pkt_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pkt_stage_buf
// Purpose  : PKT_BYTES x 8 staging register file. It holds one packet
//            payload between capture and the FIFO burst.
// Ports    : clk, reset_n  - clock, asynchronous active-low reset (clears all)
//            wr_en         - write strobe for the capture port
//            wr_idx/wr_byte- capture write address and data
//            rd_idx        - burst read address
//            rd_byte       - combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module pkt_stage_buf #(
    parameter int PKT_BYTES = 4,
    parameter int IDX_W     = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_byte,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_byte
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(PKT_BYTES - 1);

    logic [7:0] r_mem [PKT_BYTES];

    // When PKT_BYTES is not a power of two, the index range is larger than
    // the array. Addresses beyond the last entry are ignored on write and
    // read back as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PKT_BYTES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en && (wr_idx <= c_last_idx)) begin
            r_mem[wr_idx] <= wr_byte;
        end
    end

    assign rd_byte = (rd_idx <= c_last_idx) ? r_mem[rd_idx] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/ctrl_50mhz.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_50mhz
// Purpose  : Producer-side controller for the byte FIFO that feeds the
//            2 MHz domain. It detects a header byte and captures a
//            fixed-length payload. It then writes the whole payload into the
//            FIFO as one contiguous group, so the downstream reader stays
//            word-aligned. A header that arrives while a burst is still
//            pending is dropped as a whole packet.
// Ports    : clk, reset_n  - 50 MHz clock, asynchronous active-low reset
//            data_ena      - data_in valid strobe
//            data_in       - incoming byte
//            fifo_full     - FIFO cannot take a write this cycle
//            wr_fifo       - FIFO write strobe (one byte per cycle)
//            wr_data       - byte to write (0 outside BURST)
//            pkt_done      - pulse coincident with the last payload write
//            pkt_drop      - pulse the cycle after a rejected header
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_50mhz
    import ctrl_pkg::*;
#(
    parameter logic [7:0] HDR_A     = c_hdr_a,
    parameter logic [7:0] HDR_B     = c_hdr_b,
    parameter int         PKT_BYTES = c_pkt_bytes
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       data_ena,
    input  logic [7:0] data_in,
    input  logic       fifo_full,
    output logic       wr_fifo,
    output logic [7:0] wr_data,
    output logic       pkt_done,
    output logic       pkt_drop
);

    localparam int               c_idx_w    = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PKT_BYTES - 1);

    ctrl_state_t        r_state;
    ctrl_state_t        w_state_next;
    logic [c_idx_w-1:0] r_cnt;
    logic [c_idx_w-1:0] w_cnt_next;
    logic [c_idx_w-1:0] r_wr_idx;
    logic [c_idx_w-1:0] w_wr_idx_next;
    logic               r_pkt_drop;
    logic               w_drop_next;
    logic               w_cap_we;
    logic               w_is_hdr;
    logic [7:0]         w_rd_byte;

    assign w_is_hdr = is_header(data_in, HDR_A, HDR_B);
    assign pkt_drop = r_pkt_drop;

    pkt_stage_buf #(
        .PKT_BYTES (PKT_BYTES),
        .IDX_W     (c_idx_w)
    ) u_stage_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_cap_we),
        .wr_idx  (r_cnt),
        .wr_byte (data_in),
        .rd_idx  (r_wr_idx),
        .rd_byte (w_rd_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= HDR_WAIT;
            r_cnt      <= '0;
            r_wr_idx   <= '0;
            r_pkt_drop <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_wr_idx   <= w_wr_idx_next;
            r_pkt_drop <= w_drop_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_wr_idx_next = r_wr_idx;
        w_drop_next   = 1'b0;
        w_cap_we      = 1'b0;
        wr_fifo       = 1'b0;
        wr_data       = 8'h00;
        pkt_done      = 1'b0;

        case (r_state)
            HDR_WAIT: begin
                if (data_ena && w_is_hdr) begin
                    w_state_next = CAPTURE;
                    w_cnt_next   = '0;
                end
            end

            CAPTURE: begin
                // Header values are ordinary payload here. There is no
                // timeout, so idle cycles hold the state.
                if (data_ena) begin
                    w_cap_we = 1'b1;
                    if (r_cnt == c_last_idx) begin
                        w_state_next  = BURST;
                        w_cnt_next    = '0;
                        w_wr_idx_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            BURST: begin
                wr_fifo = !fifo_full;
                wr_data = w_rd_byte;
                // The staging buffer is busy, so a new header is rejected.
                // Its payload bytes then reach HDR_WAIT as non-headers and
                // are ignored.
                if (data_ena && w_is_hdr) begin
                    w_drop_next = 1'b1;
                end
                if (!fifo_full) begin
                    if (r_wr_idx == c_last_idx) begin
                        pkt_done      = 1'b1;
                        w_state_next  = HDR_WAIT;
                        w_wr_idx_next = '0;
                    end else begin
                        w_wr_idx_next = r_wr_idx + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next  = HDR_WAIT;
                w_cnt_next    = '0;
                w_wr_idx_next = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_50mhz.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_50mhz
// Purpose  : Directed self-checking bench for ctrl_50mhz (PKT_BYTES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_50mhz;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       data_ena  = 1'b0;
    logic [7:0] data_in   = 8'h00;
    logic       fifo_full = 1'b0;
    logic       wr_fifo;
    logic [7:0] wr_data;
    logic       pkt_done;
    logic       pkt_drop;

    int checks   = 0;
    int failures = 0;

    // Monitor state: written only by the monitor process.
    int         cyc       = 0;
    logic [7:0] wr_q[$];
    int         wr_cyc[$];
    int         done_cnt  = 0;
    int         drop_cnt  = 0;
    int         done_bad  = 0;
    logic [7:0] done_byte = 8'h00;

    int last_ena_cyc = 0;

    ctrl_50mhz #(
        .HDR_A     (8'hA5),
        .HDR_B     (8'hC3),
        .PKT_BYTES (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_ena  (data_ena),
        .data_in   (data_in),
        .fifo_full (fifo_full),
        .wr_fifo   (wr_fifo),
        .wr_data   (wr_data),
        .pkt_done  (pkt_done),
        .pkt_drop  (pkt_drop)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample the outputs on the falling edge, halfway between active edges.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (wr_fifo === 1'b1) begin
                wr_q.push_back(wr_data);
                wr_cyc.push_back(cyc);
            end
            if (pkt_done === 1'b1) begin
                done_cnt  = done_cnt + 1;
                done_byte = wr_data;
                if (wr_fifo !== 1'b1) done_bad = done_bad + 1;
            end
            if (pkt_drop === 1'b1) drop_cnt = drop_cnt + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_ena = 1'b1;
        data_in  = b;
        tick();
        data_ena = 1'b0;
        data_in  = 8'h00;
        last_ena_cyc = cyc;
    endtask

    // Header plus four payload bytes on isolated strobes, with no gap after
    // the last byte.
    task automatic send_seq(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0); gap(1);
        send_byte(b1); gap(1);
        send_byte(b2); gap(1);
        send_byte(b3); gap(1);
        send_byte(b4);
    endtask

    task automatic check_writes(input string tag, input int base,
                                input logic [7:0] e0, e1, e2, e3);
        logic [7:0] exp [4];
        logic [7:0] obs;
        exp = '{e0, e1, e2, e3};
        chk({tag, "_count"}, wr_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            obs = (base + i < wr_q.size()) ? wr_q[base + i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, obs}, {24'h0, exp[i]});
        end
    endtask

    initial begin
        int base;
        int dbase;
        int pbase;
        logic [8:0] pat;

        // ---------------- reset state ----------------
        #25;
        chk("rst_wr_fifo",  wr_fifo,  1'b0);
        chk("rst_wr_data",  wr_data,  8'h00);
        chk("rst_pkt_done", pkt_done, 1'b0);
        chk("rst_pkt_drop", pkt_drop, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        gap(2);

        // ---------------- basic packet ----------------
        base = wr_q.size(); dbase = done_cnt;
        send_seq(8'hA5, 8'h11, 8'h22, 8'h33, 8'h44);
        gap(8);
        check_writes("basic", base, 8'h11, 8'h22, 8'h33, 8'h44);
        if (wr_cyc.size() >= base + 4) begin
            chk("basic_first_latency", wr_cyc[base], last_ena_cyc);
            chk("basic_consecutive",   wr_cyc[base + 3] - wr_cyc[base], 3);
        end else begin
            chk("basic_write_cycles_present", wr_cyc.size() - base, 4);
        end
        chk("basic_done_cnt",  done_cnt - dbase, 1);
        chk("basic_done_byte", done_byte, 8'h44);
        chk("basic_idle_after", wr_fifo, 1'b0);

        // ---------------- noise then header B ----------------
        base = wr_q.size(); dbase = done_cnt;
        send_byte(8'h00); gap(1);
        send_byte(8'h7F); gap(3);
        chk("noise_no_writes", wr_q.size() - base, 0);
        send_seq(8'hC3, 8'h01, 8'h02, 8'h03, 8'h04);
        gap(8);
        check_writes("hdrb", base, 8'h01, 8'h02, 8'h03, 8'h04);
        chk("hdrb_done_cnt", done_cnt - dbase, 1);

        // ---------------- back-pressure stall ----------------
        base = wr_q.size(); dbase = done_cnt;
        fifo_full = 1'b1;
        send_seq(8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        gap(10);
        chk("stall_no_writes", wr_q.size() - base, 0);
        chk("stall_no_done",   done_cnt - dbase, 0);
        fifo_full = 1'b0;
        gap(6);
        check_writes("stall", base, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        chk("stall_done_cnt",  done_cnt - dbase, 1);
        chk("stall_done_byte", done_byte, 8'hDD);

        // ---------------- fifo_full toggling mid-burst ----------------
        base = wr_q.size(); dbase = done_cnt;
        fifo_full = 1'b1;
        send_seq(8'hA5, 8'h10, 8'h20, 8'h30, 8'h40);
        pat = 9'b010110100;   // applied LSB first: 0,0,1,0,1,1,0,1,0
        for (int i = 0; i < 9; i++) begin
            fifo_full = pat[i];
            tick();
        end
        fifo_full = 1'b0;
        gap(4);
        check_writes("toggle", base, 8'h10, 8'h20, 8'h30, 8'h40);
        chk("toggle_done_cnt",  done_cnt - dbase, 1);
        chk("toggle_done_byte", done_byte, 8'h40);

        // ---------------- header dropped during burst ----------------
        base = wr_q.size(); dbase = done_cnt; pbase = drop_cnt;
        fifo_full = 1'b1;
        send_seq(8'hA5, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
        gap(2);
        data_ena = 1'b1;
        data_in  = 8'hC3;
        chk("drop_before", pkt_drop, 1'b0);
        tick();
        data_ena = 1'b0;
        data_in  = 8'h00;
        chk("drop_pulse", pkt_drop, 1'b1);
        tick();
        chk("drop_pulse_end", pkt_drop, 1'b0);
        send_byte(8'h55); gap(1);
        send_byte(8'h66); gap(1);
        send_byte(8'h77); gap(1);
        send_byte(8'h88); gap(2);
        chk("drop_stalled_no_writes", wr_q.size() - base, 0);
        fifo_full = 1'b0;
        gap(12);
        check_writes("drop", base, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
        chk("drop_cnt",      drop_cnt - pbase, 1);
        chk("drop_done_cnt", done_cnt - dbase, 1);

        // ---------------- payload with header values + header in last write cycle ----------------
        base = wr_q.size(); dbase = done_cnt; pbase = drop_cnt;
        send_seq(8'hA5, 8'hA5, 8'hC3, 8'hA5, 8'hC3);
        gap(3);
        // The last burst write happens in this cycle, so this header is still
        // seen in BURST and is rejected.
        data_ena = 1'b1;
        data_in  = 8'hA5;
        tick();
        data_ena = 1'b0;
        data_in  = 8'h00;
        chk("edge_drop_pulse", pkt_drop, 1'b1);
        chk("edge_idle",       wr_fifo,  1'b0);
        send_byte(8'h01); gap(1);
        send_byte(8'h02); gap(1);
        send_byte(8'h03); gap(1);
        send_byte(8'h04); gap(6);
        check_writes("hdrdata", base, 8'hA5, 8'hC3, 8'hA5, 8'hC3);
        chk("hdrdata_done_cnt", done_cnt - dbase, 1);
        chk("hdrdata_drop_cnt", drop_cnt - pbase, 1);

        // ---------------- reset mid-capture ----------------
        base = wr_q.size();
        send_byte(8'hA5); gap(1);
        send_byte(8'h01); gap(1);
        send_byte(8'h02);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rstcap_wr_fifo",  wr_fifo,  1'b0);
        chk("rstcap_wr_data",  wr_data,  8'h00);
        chk("rstcap_pkt_done", pkt_done, 1'b0);
        chk("rstcap_pkt_drop", pkt_drop, 1'b0);
        tick();
        reset_n = 1'b1;
        gap(2);

        // ---------------- reset mid-burst (asynchronous) ----------------
        send_seq(8'hA5, 8'hF1, 8'hF2, 8'hF3, 8'hF4);
        chk("rstburst_pre_wr_fifo", wr_fifo, 1'b1);
        chk("rstburst_pre_wr_data", wr_data, 8'hF1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstburst_wr_fifo",  wr_fifo,  1'b0);
        chk("rstburst_wr_data",  wr_data,  8'h00);
        chk("rstburst_pkt_done", pkt_done, 1'b0);
        tick();
        reset_n = 1'b1;
        gap(2);
        chk("rstburst_no_writes", wr_q.size() - base, 0);

        base = wr_q.size(); dbase = done_cnt;
        send_seq(8'hA5, 8'h09, 8'h08, 8'h07, 8'h06);
        gap(8);
        check_writes("postrst", base, 8'h09, 8'h08, 8'h07, 8'h06);
        chk("postrst_done_cnt", done_cnt - dbase, 1);

        chk("done_always_with_write", done_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
